fetch_queue: RTL and testbench

//  Decoupling instruction buffer between the fetch stage and decode. Accepts one fetched
//  {pc, instruction, compressed flag} per cycle via valid/ready; presents the oldest entry
//  to decode via valid/ready. Redirects (branch, jal/jalr, trap entry/return) flush it in one cycle.

---
 rtl/riscv_fetch_pkg.sv | 11 +
 rtl/fetch_queue_mem.sv | 23 ++
 rtl/fetch_queue.sv | 71 +++++++
 tb/tb_fetch_queue.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types: the entry carried from fetch to decode.
package riscv_fetch_pkg;
  localparam int FQ_XLEN          = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] ins;
    logic               comp;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);
  // Contents are deliberately not reset; occupancy gates visibility.
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with single-cycle flush on redirect.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic                     clk,
  input  logic                     Rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_ins,
  input  logic                     in_comp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_ins,
  output logic                     out_comp,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  fetch_entry_t  wdata, head;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wdata = '{pc: in_pc, ins: in_ins, comp: in_comp};

  // A flushed push may still write storage; the pointer reset makes it invisible.
  fetch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents a zero bubble that decode treats as a NOP.
  assign out_pc   = out_valid ? head.pc   : '0;
  assign out_ins  = out_valid ? head.ins  : '0;
  assign out_comp = out_valid ? head.comp : 1'b0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue.
module tb_fetch_queue;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             Rst_n, flush, in_valid, in_ready, in_comp;
  logic [XLEN-1:0]  in_pc, in_ins, out_pc, out_ins;
  logic             out_valid, out_ready, out_comp;
  logic [$clog2(DEPTH):0] count;

  fetch_entry_t q[$];
  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins), .in_comp(in_comp),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_comp(out_comp), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic c, input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_ins = ins; in_comp = c; out_ready = ordy; flush = fl;
  endtask

  // Checks occupancy/handshake and the head entry against the model.
  task automatic check_state(input string tag);
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
    if (q.size() != 0) begin
      chk({tag, ".out_pc"},   64'(out_pc),   64'(q[0].pc));
      chk({tag, ".out_ins"},  64'(out_ins),  64'(q[0].ins));
      chk({tag, ".out_comp"}, 64'(out_comp), 64'(q[0].comp));
    end else begin
      chk({tag, ".bubble"}, {out_pc, out_ins[30:0], out_comp}, 64'h0);
    end
  endtask

  // Called at posedge+1 with inputs driven; model decides push/pop, then one edge.
  task automatic tick(input string tag);
    bit mpush, mpop;
    fetch_entry_t e;
    mpush = in_valid && (q.size() != DEPTH);
    mpop  = out_ready && (q.size() != 0);
    if (mpop) begin
      e = q.pop_front();
      chk({tag, ".pop_pc"},   64'(out_pc),   64'(e.pc));
      chk({tag, ".pop_ins"},  64'(out_ins),  64'(e.ins));
      chk({tag, ".pop_comp"}, 64'(out_comp), 64'(e.comp));
    end
    if (mpush && !flush) q.push_back('{pc: in_pc, ins: in_ins, comp: in_comp});
    if (flush) q.delete();
    @(posedge clk); #1;
    check_state(tag);
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check_state("reset");
    #5 Rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(i*4), 32'h1000_0013 + 32'(i), 0, 0, 0);
      tick("pre_rst");
    end
    drive(0, 0, 0, 0, 0, 0);
    #1 Rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst.count",     64'(count),     64'h0);
    chk("async_rst.out_valid", 64'(out_valid), 64'h0);
    chk("async_rst.in_ready",  64'(in_ready),  64'h1);
    chk("async_rst.out_ins",   64'(out_ins),   64'h0);
    #1 Rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("post_rst");

    // Fill to DEPTH, then an ignored fifth push
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i*4), 32'h2000_0013 + 32'(i*4), 0, 0, 0);
      tick("fill");
    end
    drive(1, 32'h10, 32'h2000_0023, 0, 0, 0);
    tick("fill_over");
    chk("fill.head_pc", 64'(out_pc), 64'h0);

    // Drain in order, then one bubble cycle
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick("drain");
    end

    // Simultaneous push/pop at count=1
    drive(1, 32'h20, 32'h3000_0013, 0, 0, 0);
    tick("pp_load");
    drive(1, 32'h24, 32'h3000_0017, 0, 1, 0);
    tick("pp_swap");
    chk("pp.head_pc", 64'(out_pc), 64'h24);

    // Flush beats same-cycle push and pop at count=2
    drive(1, 32'h28, 32'h4000_0013, 0, 0, 0);
    tick("fl_load");
    drive(1, 32'h40, 32'h4000_0017, 0, 1, 1);
    tick("flush");
    chk("flush.count", 64'(count), 64'h0);
    drive(1, 32'h80, 32'h5000_0013, 0, 0, 0);
    tick("post_flush");
    chk("post_flush.pc", 64'(out_pc), 64'h80);

    // Push/pop pairs across pointer wrap, alternating compressed encodings
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1, 32'h200 + 32'(i*2), 32'h0000_4501, 1, 1, 0);
      else            drive(1, 32'h200 + 32'(i*2), 32'h0000_0013, 0, 1, 0);
      tick("wrap");
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick("wrap_drain");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
